ifc_value_arbiter: RTL

//  Shares one WIDTH-bit value register among NREQ requesters.
//  - The register is the shared store held in a parameterised interface.
//  - Each requester drives req + wdata. The arbiter picks one winner, commits
//    its wdata, returns a one-cycle ack, then optionally enforces a cooldown.
//  - Sits between sub-module writers and the shared interface value.

---
 rtl/ifc_arb_pkg.sv | 10 +
 rtl/ifc_arb_pick.sv | 33 +++
 rtl/ifc_value_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ifc_arb_pkg.sv
// Shared types and constants for the ifc_value_arbiter block.
package ifc_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_COOL} arb_state_e;

   localparam int unsigned MODE_RR    = 0;
   localparam int unsigned MODE_FIXED = 1;
   localparam int unsigned STAT_W     = 16;

endpackage

// File: rtl/ifc_arb_pick.sv
// Combinational winner picker: round-robin after rr_last, or lowest index first.
module ifc_arb_pick
   import ifc_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned MODE = MODE_RR,
   localparam int unsigned IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] elig,
   input  logic [IDW-1:0]  rr_last,
   output logic            any,
   output logic [IDW-1:0]  winner
);

   always_comb begin
      int unsigned k;
      any    = 1'b0;
      winner = '0;
      k      = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (MODE == MODE_FIXED) begin
            k = i;
         end else begin
            k = (32'(rr_last) + i + 1) % NREQ;
         end
         if (!any && elig[k[IDW-1:0]]) begin
            any    = 1'b1;
            winner = k[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/ifc_value_arbiter.sv
// Arbitrates NREQ writers onto one shared value register with a post-commit cooldown.
// Optional per-requester grant counters are built when IFC_ARB_STATS_EN is defined.
module ifc_value_arbiter
   import ifc_arb_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MODE     = 0,
   parameter int unsigned COOLDOWN = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         ack,
   output logic [$clog2(NREQ)-1:0] gnt_id,
   output logic [WIDTH-1:0]        value,
   output logic                    value_vld,
   output logic                    busy
`ifdef IFC_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0]  stat_cnt
`endif
);

   localparam int unsigned IDW = $clog2(NREQ);

   if (!(MODE == MODE_RR || MODE == MODE_FIXED) || NREQ < 2 || NREQ > 16 || COOLDOWN > 15)
   begin : g_bad_param
      $error("ifc_value_arbiter: illegal MODE/NREQ/COOLDOWN");
   end

   arb_state_e       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             vld_q, vld_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic [IDW-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0]   rr_q, rr_d;

   logic [NREQ-1:0]  elig;
   logic             any;
   logic [IDW-1:0]   win;
   logic [WIDTH-1:0] win_data;

   // A requester is masked while its ack is visible so a held req is not re-granted stale data.
   assign elig = req & ~ack_q;

   ifc_arb_pick #(
      .NREQ (NREQ),
      .MODE (MODE)
   ) u_pick (
      .elig    (elig),
      .rr_last (rr_q),
      .any     (any),
      .winner  (win)
   );

   always_comb begin
      win_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == IDW'(k)) win_data = wdata[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      value_d = value_q;
      vld_d   = vld_q;
      ack_d   = '0;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (any) begin
               value_d    = win_data;
               vld_d      = 1'b1;
               gnt_d      = win;
               rr_d       = win;
               ack_d[win] = 1'b1;
               if (COOLDOWN > 0) begin
                  state_d = ARB_COOL;
                  cnt_d   = 4'(COOLDOWN - 1);
               end
            end
         end
         ARB_COOL: begin
            if (cnt_q == 4'd0) begin
               state_d = ARB_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         cnt_q   <= '0;
         value_q <= '0;
         vld_q   <= 1'b0;
         ack_q   <= '0;
         gnt_q   <= '0;
         rr_q    <= IDW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         vld_q   <= vld_d;
         ack_q   <= ack_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
      end
   end

   assign ack       = ack_q;
   assign gnt_id    = gnt_q;
   assign value     = value_q;
   assign value_vld = vld_q;
   assign busy      = (state_q == ARB_COOL);

`ifdef IFC_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NREQ];
   logic [STAT_W-1:0] stat_d [NREQ];

   // Counters bump on the commit edge so the count is visible alongside the ack.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         stat_d[k] = stat_q[k];
         if (ack_d[k] && (stat_q[k] != '1)) stat_d[k] = stat_q[k] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NREQ; k++) begin
         if (rst) stat_q[k] <= '0;
         else     stat_q[k] <= stat_d[k];
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_stat
      assign stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
   end
`endif

endmodule
